// File: rtl/seven_seg_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller: slot FSM encoding,
// segment constants and a constant-foldable ceil(log2) helper.
package seven_seg_scan_controller_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } slot_state_e;

   localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}, combinational.
module hex_to_7seg (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = 7'h7F;
      case (hex_i)
         4'h0: seg_n_o = 7'h40;
         4'h1: seg_n_o = 7'h79;
         4'h2: seg_n_o = 7'h24;
         4'h3: seg_n_o = 7'h30;
         4'h4: seg_n_o = 7'h19;
         4'h5: seg_n_o = 7'h12;
         4'h6: seg_n_o = 7'h02;
         4'h7: seg_n_o = 7'h78;
         4'h8: seg_n_o = 7'h00;
         4'h9: seg_n_o = 7'h10;
         4'hA: seg_n_o = 7'h08;
         4'hB: seg_n_o = 7'h03;
         4'hC: seg_n_o = 7'h46;
         4'hD: seg_n_o = 7'h21;
         4'hE: seg_n_o = 7'h06;
         4'hF: seg_n_o = 7'h0E;
         default: seg_n_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seven_seg_slot_timer.sv
// Per-digit slot counter with BLANK/ON phases; flags slot and frame ends.
// slot_on_o reflects the phase of the coming cycle so registered outputs align.
module seven_seg_slot_timer
   import seven_seg_scan_controller_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SLOT_CYCLES  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [clog2(NUM_DIGITS)-1:0] digit_idx_i,
   output logic                         slot_on_o,
   output logic                         slot_end_o,
   output logic                         frame_end_o
);

   localparam int unsigned CW = clog2(SLOT_CYCLES);
   localparam int unsigned IW = clog2(NUM_DIGITS);

   slot_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_slot_end;

   assign at_slot_end = (state_q == ST_ON) && (cnt_q == CW'(SLOT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         ST_BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = ST_ON;
         ST_ON: begin
            if (at_slot_end) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   always_comb begin
      slot_on_o   = (state_d == ST_ON);
      slot_end_o  = at_slot_end;
      frame_end_o = at_slot_end && (digit_idx_i == IW'(NUM_DIGITS - 1));
   end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed common-anode seven-segment scanner with one shared decoder
// and a frame-boundary update handshake.
module seven_seg_scan_controller
   import seven_seg_scan_controller_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SLOT_CYCLES  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic [4*NUM_DIGITS-1:0]      value_in,
   input  logic [NUM_DIGITS-1:0]        blank_in,
   input  logic [NUM_DIGITS-1:0]        dp_in,
   output logic                         load_ready,
   output logic [6:0]                   seg_n,
   output logic                         dp_n,
   output logic [NUM_DIGITS-1:0]        an_n,
   output logic [clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                         frame_tick
);

   localparam int unsigned IW = clog2(NUM_DIGITS);

   if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SLOT_CYCLES < 4 ||
       BLANK_CYCLES < 1 || BLANK_CYCLES > SLOT_CYCLES - 2) begin : g_param_check
      $error("seven_seg_scan_controller: parameter out of range");
   end

   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] val_q, val_d, pval_q, pval_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d, pblank_q, pblank_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d, pdp_q, pdp_d;
   logic                    pend_q, pend_d;
   logic [6:0]              seg_n_q, seg_n_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic [3:0]              nibble;
   logic                    slot_on, slot_end, frame_end;

   seven_seg_slot_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .SLOT_CYCLES (SLOT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .digit_idx_i(idx_q),
      .slot_on_o  (slot_on),
      .slot_end_o (slot_end),
      .frame_end_o(frame_end)
   );

   hex_to_7seg u_dec (
      .hex_i  (nibble),
      .seg_n_o(seg_n_d)
   );

   // Display registers are fed from next-state values so segments, anode and
   // index all change on the same edge.
   always_comb begin
      idx_d    = idx_q;
      val_d    = val_q;
      blank_d  = blank_q;
      dp_d     = dp_q;
      pval_d   = pval_q;
      pblank_d = pblank_q;
      pdp_d    = pdp_q;
      pend_d   = pend_q;
      nibble   = '0;
      dp_n_d   = 1'b1;
      an_n_d   = '1;

      if (slot_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

      // A load coinciding with a frame end while idle lands in pending only.
      if (frame_end && pend_q) begin
         val_d   = pval_q;
         blank_d = pblank_q;
         dp_d    = pdp_q;
         pend_d  = 1'b0;
      end else if (load && !pend_q) begin
         pval_d   = value_in;
         pblank_d = blank_in;
         pdp_d    = dp_in;
         pend_d   = 1'b1;
      end

      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx_d == IW'(k)) begin
            nibble    = val_d[4*k +: 4];
            dp_n_d    = ~dp_d[k];
            an_n_d[k] = ~(slot_on && !blank_d[k]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q    <= '0;
         val_q    <= '0;
         blank_q  <= '1;
         dp_q     <= '0;
         pval_q   <= '0;
         pblank_q <= '1;
         pdp_q    <= '0;
         pend_q   <= 1'b0;
         seg_n_q  <= SEG_ALL_OFF;
         dp_n_q   <= 1'b1;
         an_n_q   <= '1;
      end else begin
         idx_q    <= idx_d;
         val_q    <= val_d;
         blank_q  <= blank_d;
         dp_q     <= dp_d;
         pval_q   <= pval_d;
         pblank_q <= pblank_d;
         pdp_q    <= pdp_d;
         pend_q   <= pend_d;
         seg_n_q  <= seg_n_d;
         dp_n_q   <= dp_n_d;
         an_n_q   <= an_n_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign digit_idx  = idx_q;
   assign load_ready = ~pend_q;
   assign frame_tick = frame_end;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench: stimulus queues hand-computed display snapshots per cycle,
// a negedge monitor pops and compares them, plus per-cycle structural checks.
module tb_seven_seg_scan_controller;

   typedef struct {
      int         ep;
      int         cyc;
      logic [1:0] idx;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       rdy;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  blank_in;
   logic [3:0]  dp_in;
   logic        load_ready;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   exp_t sb[$];
   int   cyc;
   int   epoch;
   int   n_chk;
   int   n_fail;

   seven_seg_scan_controller #(
      .NUM_DIGITS  (4),
      .SLOT_CYCLES (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .value_in  (value_in),
      .blank_in  (blank_in),
      .dp_in     (dp_in),
      .load_ready(load_ready),
      .seg_n     (seg_n),
      .dp_n      (dp_n),
      .an_n      (an_n),
      .digit_idx (digit_idx),
      .frame_tick(frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_at(input int ep, input int c, input logic [1:0] idx, input logic [3:0] an,
                         input logic [6:0] seg, input logic dp, input logic rdy);
      exp_t e;
      e.ep = ep; e.cyc = c; e.idx = idx; e.an = an; e.seg = seg; e.dp = dp; e.rdy = rdy;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
      load = 1'b1; value_in = v; blank_in = b; dp_in = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   always @(negedge clk) begin
      chk($sformatf("frame_tick@%0d.%0d", epoch, cyc), 32'(frame_tick), 32'((cyc % 32) == 31));
      chk($sformatf("digit_idx@%0d.%0d", epoch, cyc), 32'(digit_idx), 32'((cyc / 8) % 4));
      chk($sformatf("an_onehot@%0d.%0d", epoch, cyc), 32'($countones(~an_n) <= 1), 32'd1);
      while (sb.size() > 0 && (sb[0].ep < epoch || (sb[0].ep == epoch && sb[0].cyc < cyc))) begin
         chk($sformatf("missed@%0d.%0d", sb[0].ep, sb[0].cyc), 32'd0, 32'd1);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].ep == epoch && sb[0].cyc == cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk($sformatf("an_n@%0d.%0d", e.ep, e.cyc), 32'(an_n), 32'(e.an));
         chk($sformatf("seg_n@%0d.%0d", e.ep, e.cyc), 32'(seg_n), 32'(e.seg));
         chk($sformatf("dp_n@%0d.%0d", e.ep, e.cyc), 32'(dp_n), 32'(e.dp));
         chk($sformatf("load_ready@%0d.%0d", e.ep, e.cyc), 32'(load_ready), 32'(e.rdy));
         chk($sformatf("idx@%0d.%0d", e.ep, e.cyc), 32'(digit_idx), 32'(e.idx));
      end
   end

   initial begin
      n_chk = 0; n_fail = 0; epoch = 0;
      reset = 1'b1; load = 1'b0; value_in = '0; blank_in = '0; dp_in = '0;

      // Idle after reset: all digits blanked by reset, nibble 0 decoded.
      exp_at(0, 0, 2'd0, 4'hF, 7'h7F, 1'b1, 1'b1);
      exp_at(0, 1, 2'd0, 4'hF, 7'h40, 1'b1, 1'b1);
      exp_at(0, 3, 2'd0, 4'hF, 7'h40, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Load 4321 at cycle 5; a second load at 7 must be ignored.
      exp_at(0, 6,  2'd0, 4'hF, 7'h40, 1'b1, 1'b0);
      exp_at(0, 20, 2'd2, 4'hF, 7'h40, 1'b1, 1'b0);
      exp_at(0, 31, 2'd3, 4'hF, 7'h40, 1'b1, 1'b0);
      wait_cyc(5);
      do_load(16'h4321, 4'b0000, 4'b0100);
      wait_cyc(7);
      do_load(16'h9999, 4'b1111, 4'b1111);

      exp_at(0, 32, 2'd0, 4'hF, 7'h79, 1'b1, 1'b1);
      exp_at(0, 34, 2'd0, 4'hE, 7'h79, 1'b1, 1'b1);
      exp_at(0, 42, 2'd1, 4'hD, 7'h24, 1'b1, 1'b1);
      exp_at(0, 50, 2'd2, 4'hB, 7'h30, 1'b0, 1'b1);
      exp_at(0, 58, 2'd3, 4'h7, 7'h19, 1'b1, 1'b1);
      exp_at(0, 63, 2'd3, 4'h7, 7'h19, 1'b1, 1'b1);

      // Load on the frame_tick cycle: applies one frame later.
      wait_cyc(63);
      do_load(16'h8765, 4'b0000, 4'b0001);
      exp_at(0, 64, 2'd0, 4'hF, 7'h79, 1'b1, 1'b0);
      exp_at(0, 66, 2'd0, 4'hE, 7'h79, 1'b1, 1'b0);
      exp_at(0, 95, 2'd3, 4'h7, 7'h19, 1'b1, 1'b0);
      exp_at(0, 96, 2'd0, 4'hF, 7'h12, 1'b0, 1'b1);
      exp_at(0, 98, 2'd0, 4'hE, 7'h12, 1'b0, 1'b1);

      // Blank digits 1 and 3.
      wait_cyc(100);
      do_load(16'hFEDC, 4'b1010, 4'b0000);
      exp_at(0, 106, 2'd1, 4'hD, 7'h02, 1'b1, 1'b0);
      exp_at(0, 127, 2'd3, 4'h7, 7'h00, 1'b1, 1'b0);
      exp_at(0, 128, 2'd0, 4'hF, 7'h46, 1'b1, 1'b1);
      exp_at(0, 130, 2'd0, 4'hE, 7'h46, 1'b1, 1'b1);
      exp_at(0, 138, 2'd1, 4'hF, 7'h21, 1'b1, 1'b1);
      exp_at(0, 146, 2'd2, 4'hB, 7'h06, 1'b1, 1'b1);
      exp_at(0, 154, 2'd3, 4'hF, 7'h0E, 1'b1, 1'b1);

      // Pending update, then reset during digit 2's ON phase.
      wait_cyc(160);
      do_load(16'h1111, 4'b0000, 4'b0000);
      exp_at(0, 170, 2'd1, 4'hF, 7'h21, 1'b1, 1'b0);
      exp_at(0, 179, 2'd2, 4'hB, 7'h06, 1'b1, 1'b0);
      exp_at(1, 0,  2'd0, 4'hF, 7'h7F, 1'b1, 1'b1);
      exp_at(1, 1,  2'd0, 4'hF, 7'h40, 1'b1, 1'b1);
      exp_at(1, 3,  2'd0, 4'hF, 7'h40, 1'b1, 1'b1);
      exp_at(1, 31, 2'd3, 4'hF, 7'h40, 1'b1, 1'b1);
      exp_at(1, 34, 2'd0, 4'hF, 7'h40, 1'b1, 1'b1);
      exp_at(1, 50, 2'd2, 4'hF, 7'h40, 1'b1, 1'b1);
      wait_cyc(179);
      @(posedge clk);
      #1;
      reset = 1'b1;
      epoch = 1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      wait_cyc(60);
      while (sb.size() > 0) begin
         chk($sformatf("unchecked@%0d.%0d", sb[0].ep, sb[0].cyc), 32'd0, 32'd1);
         void'(sb.pop_front());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
